// File: rtl/shake_hand_send_if.sv
// Signal bundle between local logic, the handshake transmitter and its remote receiver.
// master = transmitter side, slave = local writer plus remote receiver.
interface shake_hand_send_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic [AW:0]   count;
    logic          ack;
    logic          ready;
    logic [DW-1:0] dout;
    logic          sent;

    modport master (
        input  wr_en, wr_data, ack,
        output full, count, ready, dout, sent
    );

    modport slave (
        output wr_en, wr_data, ack,
        input  full, count, ready, dout, sent
    );
endinterface

// File: rtl/shake_hand_send.sv
// Transmit side of a four-phase ready/ack link: a small FIFO feeds bytes to a
// receiver on an unrelated clock, one byte per complete handshake.
module shake_hand_send #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    shake_hand_send_if.master  io_bus
);
    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_ack_d1, r_ack_d2;
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count, w_count_nxt;
    logic          r_full;
    logic          r_ready, w_ready_nxt;
    logic          r_sent, w_sent_nxt;
    logic [DW-1:0] r_dout;
    logic          w_wr, w_pop;

    // Two-flop synchronizer; nothing downstream looks at the raw ack pin.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_d1 <= 1'b0;
            r_ack_d2 <= 1'b0;
        end else begin
            r_ack_d1 <= io_bus.ack;
            r_ack_d2 <= r_ack_d1;
        end
    end

    assign w_wr = io_bus.wr_en && !r_full;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_ready_nxt = 1'b0;
        w_sent_nxt  = 1'b0;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_count != '0 && r_ack_d2) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ready_nxt = 1'b1;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!r_ack_d2) begin
                    w_sent_nxt  = 1'b1;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_ack_d2) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b0;
            r_sent   <= 1'b0;
            r_dout   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
            r_sent  <= w_sent_nxt;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_dout   <= r_mem[r_rd_ptr];
            end
        end
    end

    // NOTE: storage array is not reset; count/pointers already mark every entry invalid.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= io_bus.wr_data;
    end

    assign io_bus.ready = r_ready;
    assign io_bus.dout  = r_dout;
    assign io_bus.sent  = r_sent;
    assign io_bus.count = r_count;
    assign io_bus.full  = r_full;
endmodule

// File: tb/tb_shake_hand_send.sv
// Directed bench for shake_hand_send: reset, single byte, burst/full,
// write-with-pop, random-delay streaming and reset mid-transfer.
module tb_shake_hand_send;
    localparam int DW = 8;
    localparam int AW = 2;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   n_sent;
    int   n_unstable;
    logic          prev_ready;
    logic [DW-1:0] prev_dout;

    shake_hand_send_if #(.DW(DW), .AW(AW)) bus ();

    shake_hand_send #(.DW(DW), .AW(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitors sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.sent === 1'b1) n_sent <= n_sent + 1;
        if (bus.ready === 1'b1 && prev_ready === 1'b1 && bus.dout !== prev_dout)
            n_unstable <= n_unstable + 1;
        prev_ready <= bus.ready;
        prev_dout  <= bus.dout;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        step(1);
        bus.wr_en   = 1'b0;
    endtask

    // Behavioural receiver: arm, wait for ready, take dout, release, wait for ready low.
    task automatic recv_byte(input int d_rise, input int d_fall, output logic [DW-1:0] b);
        bit got;
        b = 'x;
        step(d_rise);
        bus.ack = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            step(1);
            if (bus.ready === 1'b1) got = 1'b1;
        end
        if (!got) begin
            check("ready_rise_timeout", 0, 1);
            return;
        end
        b = bus.dout;
        step(d_fall);
        bus.ack = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step(1);
            if (bus.ready === 1'b0) got = 1'b1;
        end
        if (!got) check("ready_fall_timeout", 0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] b;
        int sent0;
        n_cmp = 0; n_err = 0; n_sent = 0; n_unstable = 0;
        prev_ready = 1'b0; prev_dout = '0;
        rst_n = 1'b0;
        bus.ack = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;

        // Reset with ack high and write pulses
        step(1);
        for (int i = 0; i < 3; i++) write_byte(8'hE0 + 8'(i));
        check("rst_ready", 32'(bus.ready), 0);
        check("rst_dout",  32'(bus.dout), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_full",  32'(bus.full), 0);
        check("rst_sent",  32'(n_sent), 0);
        rst_n = 1'b1;
        step(3);

        // Single byte with ack already synchronized high
        write_byte(8'hA5);
        check("single_count_after_wr", 32'(bus.count), 1);
        check("single_ready_e0", 32'(bus.ready), 0);
        step(1);
        check("single_dout_e1",  32'(bus.dout), 32'hA5);
        check("single_ready_e1", 32'(bus.ready), 0);
        step(1);
        check("single_ready_e2", 32'(bus.ready), 1);
        bus.ack = 1'b0;
        step(2);
        check("single_ready_held", 32'(bus.ready), 1);
        check("single_sent_early", 32'(bus.sent), 0);
        step(1);
        check("single_ready_fall", 32'(bus.ready), 0);
        check("single_sent_pulse", 32'(bus.sent), 1);
        step(1);
        check("single_sent_end", 32'(bus.sent), 0);
        bus.ack = 1'b1;
        step(3);
        check("single_count_end", 32'(bus.count), 0);
        check("single_ready_end", 32'(bus.ready), 0);
        check("single_sent_total", 32'(n_sent), 1);

        // Burst into a 4-deep FIFO with the receiver not armed
        bus.ack = 1'b0;
        step(3);
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        check("burst_count", 32'(bus.count), 4);
        check("burst_full",  32'(bus.full), 1);
        sent0 = n_sent;
        for (int i = 1; i <= 4; i++) begin
            recv_byte(1, 2, b);
            check($sformatf("burst_byte%0d", i), 32'(b), 32'(i));
        end
        bus.ack = 1'b1;
        step(4);
        check("burst_sent_cnt", 32'(n_sent - sent0), 4);
        check("burst_count_end", 32'(bus.count), 0);
        check("burst_full_end",  32'(bus.full), 0);

        // Write in the same cycle as IDLE->LOAD
        bus.ack = 1'b0;
        step(3);
        write_byte(8'h11);
        bus.ack = 1'b1;
        step(2);
        write_byte(8'h77);
        check("simul_count", 32'(bus.count), 1);
        check("simul_dout_load", 32'(bus.dout), 32'h11);
        recv_byte(0, 1, b);
        check("simul_first", 32'(b), 32'h11);
        recv_byte(0, 1, b);
        check("simul_second", 32'(b), 32'h77);
        bus.ack = 1'b1;
        step(4);
        check("simul_count_end", 32'(bus.count), 0);

        // Stream 20 bytes with random receiver delays, concurrent writer
        n_unstable = 0;
        fork
            begin
                int i;
                int guard;
                i = 0;
                guard = 0;
                while (i < 20 && guard < 3000) begin
                    if (bus.full === 1'b0) begin
                        bus.wr_en   = 1'b1;
                        bus.wr_data = 8'h30 + 8'(i);
                        i++;
                    end else begin
                        bus.wr_en = 1'b0;
                    end
                    step(1);
                    guard++;
                end
                bus.wr_en = 1'b0;
            end
            begin
                logic [DW-1:0] rb;
                for (int j = 0; j < 20; j++) begin
                    recv_byte(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), rb);
                    check($sformatf("wrap_byte%0d", j), 32'(rb), 32'(8'h30 + 8'(j)));
                end
            end
        join
        bus.ack = 1'b1;
        step(4);
        check("wrap_dout_stable", 32'(n_unstable), 0);
        check("wrap_count_end", 32'(bus.count), 0);

        // Reset asserted while in HOLD
        write_byte(8'h99);
        write_byte(8'h9A);
        begin
            bit got;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                if (bus.ready === 1'b1) got = 1'b1;
                else step(1);
            end
            check("midrst_reach_hold", 32'(got), 1);
        end
        sent0 = n_sent;
        #2 rst_n = 1'b0;
        #1 check("midrst_ready_async", 32'(bus.ready), 0);
        step(2);
        rst_n = 1'b1;
        step(5);
        check("midrst_count", 32'(bus.count), 0);
        check("midrst_full",  32'(bus.full), 0);
        check("midrst_ready", 32'(bus.ready), 0);
        check("midrst_no_sent", 32'(n_sent - sent0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
